// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Generic 32-bit event counter with enable that sticks at all-ones instead of wrapping.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding imem requests, one-entry decode buffer.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [PC_W-1:0]    id_pc_o,
  output logic [INSTR_W-1:0] id_instr_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_redirect_o,
  output logic [31:0]        perf_bubble_o
`endif
);

  fetch_state_e        state_q;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     req_pc_q;
  logic                kill_q;
  logic                id_valid_q;
  logic [PC_W-1:0]     id_pc_q;
  logic [INSTR_W-1:0]  id_instr_q;
  logic [PC_W-1:0]     redir_pc;
  logic [PC_W-1:0]     pc_inc;
  logic                unused_redir_bits;

  // Targets are forced word aligned; bits above PC_W are outside the fetch window.
  assign redir_pc          = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign unused_redir_bits = ^{redirect_pc_i[31:PC_W], redirect_pc_i[1:0]};
  assign pc_inc            = pc_q + PC_W'(PC_INC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      kill_q     <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
    end else begin
      case (state_q)
        REQ: begin
          if (imem_gnt_i) begin
            req_pc_q <= pc_q;
            kill_q   <= redirect_i;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (kill_q || redirect_i) begin
              kill_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              id_instr_q <= imem_rdata_i;
              id_pc_q    <= req_pc_q;
              id_valid_q <= 1'b1;
              state_q    <= FULL;
            end
          end else if (redirect_i) begin
            kill_q <= 1'b1;
          end
        end
        FULL: begin
          if (redirect_i || id_ready_i) begin
            id_valid_q <= 1'b0;
            state_q    <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase

      // A redirect outranks the sequential increment and flushes the decode buffer.
      if (redirect_i) begin
        pc_q       <= redir_pc;
        id_valid_q <= 1'b0;
      end else if ((state_q == REQ) && imem_gnt_i) begin
        pc_q <= pc_inc;
      end
    end
  end

  assign imem_req_o  = reset_n && (state_q == REQ);
  assign imem_addr_o = pc_q;
  assign id_valid_o  = id_valid_q;
  assign id_pc_o     = id_pc_q;
  assign id_instr_o  = id_instr_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_redirect (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (redirect_i),
    .count (perf_redirect_o)
  );

  fetch_perf_cnt u_perf_bubble (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (!id_valid_q),
    .count (perf_bubble_o)
  );
`endif

`ifndef SYNTHESIS
  // A response outside WAIT means the memory broke the single-outstanding contract.
  rvalid_only_in_wait: assert property (
    @(posedge clk) disable iff (!reset_n) imem_rvalid_i |-> (state_q == WAIT)
  );
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the branch unit.
- Consumes the branch unit's redirect select and target (PcSel/BrPC), owns the architectural PC register, and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Presents fetched instructions to decode through a one-entry valid/ready output register.
- Squashes wrong-path responses after a redirect.

Parameters:
- PC_W, 9, PC width in bits; matches the branch unit's Cur_PC width.
- RESET_PC, 0, PC value loaded on reset (PC_W bits, word aligned).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- redirect_i  in  1  branch/jump taken (branch unit PcSel).
- redirect_pc_i  in  32  target (branch unit BrPC); only bits [PC_W-1:2] used, bits [1:0] forced to 0.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  PC_W  fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  32  response instruction.
- id_valid_o  out  1  instruction available to decode.
- id_ready_i  in  1  decode accepts this cycle.
- id_pc_o  out  PC_W  PC of presented instruction (feeds branch unit Cur_PC via ID/EX).
- id_instr_o  out  32  presented instruction.

Behaviour:
- Reset (async assert, sync deassert): pc_q=RESET_PC, req_pc_q=0, kill_q=0, state=REQ, id_valid_o=0, id_pc_o=0, id_instr_o=0. imem_req_o=0 while reset_n=0.
- States: REQ, WAIT, FULL.
- REQ:
  - imem_req_o=1, imem_addr_o=pc_q.
  - On imem_gnt_i: req_pc_q<=pc_q, pc_q<=pc_q+4, then go to WAIT.
- WAIT:
  - imem_req_o=0.
  - On imem_rvalid_i with kill_q=1: drop the data, clear kill_q, go to REQ.
  - On imem_rvalid_i with kill_q=0: id_instr_o<=imem_rdata_i, id_pc_o<=req_pc_q, id_valid_o<=1, go to FULL.
- FULL:
  - imem_req_o=0, outputs held stable while id_ready_i=0.
  - On id_ready_i=1: id_valid_o<=0, go to REQ.
- Latency: gnt at cycle n, rvalid at cycle n+k (k>=1), id_valid_o high at cycle n+k+1. Only one request is outstanding at any time.
- Redirect (redirect_i=1, any state) has priority over the +4 increment:
  - pc_q<=redirect_pc_i[PC_W-1:0] with bits [1:0]=0.
  - id_valid_o<=0.
  - REQ without gnt: stay in REQ; the address changes next cycle (the imem protocol permits this).
  - REQ with gnt in the same cycle: go to WAIT with kill_q<=1, because the granted request is wrong-path.
  - WAIT with no rvalid: kill_q<=1, stay in WAIT.
  - WAIT with rvalid in the same cycle: drop the data, go to REQ.
  - FULL: go to REQ; the presented instruction is discarded whether or not id_ready_i=1.
- Arithmetic: pc_q+4 wraps modulo 2^PC_W (e.g. 0x1FC -> 0x000 for PC_W=9).
- imem_rvalid_i while in REQ or FULL is ignored. A simulation-only assertion flags this case.
- Reset during WAIT: the outstanding response is lost. The memory must be reset with the same reset_n.

Optional Feature:
- Macro FETCH_PERF_CNT_EN. When defined, add two outputs:
  - perf_redirect_o [31:0]: counts cycles with redirect_i=1.
  - perf_bubble_o [31:0]: counts cycles with id_valid_o=0 and reset_n=1.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic[1:0] fetch_state_e {REQ, WAIT, FULL};
  - localparam INSTR_W=32;
  - localparam PC_INC=4.
- Optional sub-module fetch_perf_cnt: a generic saturating 32-bit counter with enable, instantiated twice under FETCH_PERF_CNT_EN.
- The core FSM stays in fetch_unit.

Test Plan:
- Reset, imem grants immediately, rvalid 1 cycle after gnt, id_ready_i=1 -> first id_pc_o=0x000 with id_instr_o=imem[0]; then 0x004, 0x008 in order; one instruction every 3 cycles.
- id_ready_i held 0 for 5 cycles in FULL -> id_valid_o, id_pc_o, id_instr_o stable and no imem_req_o; release -> next fetch at pc+4.
- Redirect to 0x0000_0080 while in WAIT, rvalid 3 cycles later -> response dropped, next imem_addr_o=0x080, next id_pc_o=0x080.
- redirect_i and imem_gnt_i in the same cycle (addr 0x010, target 0x040) -> response for 0x010 never reaches decode; next request addr 0x040.
- pc_q=0x1FC, sequential fetch -> following imem_addr_o=0x000; redirect_pc_i=0x0000_0203 -> imem_addr_o=0x000 (bits [1:0] cleared, upper bits truncated).
- FETCH_PERF_CNT_EN defined: 3 redirects and a 10-cycle decode stall -> perf_redirect_o=3, perf_bubble_o matches the counted invalid cycles; reset_n pulse mid-run -> both 0.
